// File: rtl/adc_serial_reader.sv
// Master-side controller for an 8-bit serial ADC: frames chip-select, generates sclk,
// shifts the result in MSB first and presents it with a one-cycle data_valid strobe.
module adc_serial_reader #(
    parameter int CLK_DIV     = 25,
    parameter int CS_SETUP    = 75,
    parameter int CONV_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       adc_dout,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [7:0] audio_data,
    output logic       data_valid,
    output logic       busy
);

    localparam int CNT_MAX = (CLK_DIV > CS_SETUP)
                           ? ((CLK_DIV > CONV_CYCLES) ? CLK_DIV : CONV_CYCLES)
                           : ((CS_SETUP > CONV_CYCLES) ? CS_SETUP : CONV_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(CONV_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE,
        ST_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             phase, phase_nxt;   // 0: sclk high half, 1: sclk low half
    logic [2:0]       bit_cnt, bit_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [7:0]       data_nxt;
    logic             cs_n_nxt, sclk_nxt, valid_nxt, busy_nxt;
    logic             dout_p0, dout_p1;
    logic             half_end;

    assign half_end = (cnt == HALF_LAST);

    // adc_dout is asynchronous to clk: two-flop synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_p0 <= 1'b0;
            dout_p1 <= 1'b0;
        end else begin
            dout_p0 <= adc_dout;
            dout_p1 <= dout_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_SETUP;
            ST_SETUP: if (cnt == SETUP_LAST) state_nxt = ST_SHIFT;
            ST_SHIFT: if (half_end && phase && bit_cnt == 3'd7) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == WAIT_LAST) state_nxt = enable ? ST_SETUP : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state so that every pin is a flop
    always_comb begin
        cnt_nxt   = '0;
        phase_nxt = phase;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        data_nxt  = audio_data;
        if (state_nxt == state && state != ST_IDLE && state != ST_DONE
            && !(state == ST_SHIFT && half_end))
            cnt_nxt = cnt + 1'b1;
        if (state == ST_SHIFT && half_end) begin
            phase_nxt = ~phase;
            if (!phase) shift_nxt = {shift_reg[6:0], dout_p1};
            else        bit_nxt   = bit_cnt + 3'd1;
        end
        if (state_nxt == ST_DONE) data_nxt = shift_reg;
        cs_n_nxt  = !(state_nxt == ST_SETUP || state_nxt == ST_SHIFT);
        sclk_nxt  = (state_nxt == ST_SHIFT) && !phase_nxt;
        valid_nxt = (state_nxt == ST_DONE);
        busy_nxt  = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            phase      <= 1'b0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            audio_data <= 8'h00;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            phase      <= phase_nxt;
            bit_cnt    <= bit_nxt;
            shift_reg  <= shift_nxt;
            audio_data <= data_nxt;
            adc_cs_n   <= cs_n_nxt;
            adc_sclk   <= sclk_nxt;
            data_valid <= valid_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: two instances (default and minimum parameters), each
// driven by a behavioural ADC model and watched by a frame-level scoreboard.
module tb_adc_serial_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic noise = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic en_a = 1'b0, bit_a = 1'b0;
    logic cs_a, sclk_a, dv_a, busy_a, dout_a;
    logic [7:0] data_a;
    logic en_b = 1'b0, bit_b = 1'b0;
    logic cs_b, sclk_b, dv_b, busy_b, dout_b;
    logic [7:0] data_b;

    assign dout_a = bit_a ^ noise;
    assign dout_b = bit_b ^ noise;

    adc_serial_reader dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .adc_dout(dout_a),
        .adc_cs_n(cs_a), .adc_sclk(sclk_a), .audio_data(data_a),
        .data_valid(dv_a), .busy(busy_a)
    );

    adc_serial_reader #(.CLK_DIV(3), .CS_SETUP(2), .CONV_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .adc_dout(dout_b),
        .adc_cs_n(cs_b), .adc_sclk(sclk_b), .audio_data(data_b),
        .data_valid(dv_b), .busy(busy_b)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic dv_of(input int s);
        return (s != 0) ? dv_b : dv_a;
    endfunction
    function automatic logic busy_of(input int s);
        return (s != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic cs_of(input int s);
        return (s != 0) ? cs_b : cs_a;
    endfunction

    // ADC models: MSB valid after cs_n falls, next bit after each sclk fall
    logic [7:0] q_a[$], q_b[$], exp_q_a[$], exp_q_b[$];
    logic [7:0] cur_a, cur_b;

    always begin
        @(negedge cs_a);
        cur_a = (q_a.size() > 0) ? q_a.pop_front() : 8'($urandom);
        #2 bit_a = cur_a[7];
        for (int i = 6; i >= 0; i--) begin
            @(negedge sclk_a or posedge cs_a);
            if (cs_a) break;
            #2 bit_a = cur_a[i];
        end
        if (!cs_a) @(posedge cs_a);
        if (rst_n) exp_q_a.push_back(cur_a);
    end

    always begin
        @(negedge cs_b);
        cur_b = (q_b.size() > 0) ? q_b.pop_front() : 8'($urandom);
        #2 bit_b = cur_b[7];
        for (int i = 6; i >= 0; i--) begin
            @(negedge sclk_b or posedge cs_b);
            if (cs_b) break;
            #2 bit_b = cur_b[i];
        end
        if (!cs_b) @(posedge cs_b);
        if (rst_n) exp_q_b.push_back(cur_b);
    end

    // Frame-level monitors: cs window length, sclk edge count, strobe value and shape
    int   low_a = 0, rises_a = 0, low_b = 0, rises_b = 0;
    logic pcs_a = 1'b1, psclk_a = 1'b0, pdv_a = 1'b0;
    logic pcs_b = 1'b1, psclk_b = 1'b0, pdv_b = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            low_a = 0; rises_a = 0; pcs_a = 1'b1; psclk_a = 1'b0; pdv_a = 1'b0;
        end else begin
            if (!cs_a) low_a++;
            if (sclk_a && !psclk_a) begin
                rises_a++;
                check("a_sclk_rise_inside_cs", cs_a, 0);
            end
            if (cs_a && !pcs_a) begin
                check("a_cs_low_cycles", low_a, 475);
                check("a_sclk_rises", rises_a, 8);
                low_a = 0; rises_a = 0;
            end
            if (dv_a) begin
                check("a_dv_one_cycle", pdv_a, 0);
                check("a_dv_has_model_value", exp_q_a.size() > 0, 1);
                if (exp_q_a.size() > 0) check("a_data_vs_model", data_a, exp_q_a.pop_front());
            end
            pcs_a = cs_a; psclk_a = sclk_a; pdv_a = dv_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            low_b = 0; rises_b = 0; pcs_b = 1'b1; psclk_b = 1'b0; pdv_b = 1'b0;
        end else begin
            if (!cs_b) low_b++;
            if (sclk_b && !psclk_b) begin
                rises_b++;
                check("b_sclk_rise_inside_cs", cs_b, 0);
            end
            if (cs_b && !pcs_b) begin
                check("b_cs_low_cycles", low_b, 50);
                check("b_sclk_rises", rises_b, 8);
                low_b = 0; rises_b = 0;
            end
            if (dv_b) begin
                check("b_dv_one_cycle", pdv_b, 0);
                check("b_dv_has_model_value", exp_q_b.size() > 0, 1);
                if (exp_q_b.size() > 0) check("b_data_vs_model", data_b, exp_q_b.pop_front());
            end
            pcs_b = cs_b; psclk_b = sclk_b; pdv_b = dv_b;
        end
    end

    task automatic wait_dv(input int s, input int bound, output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dv_of(s) && n < bound);
        check((s != 0) ? "b_dv_seen" : "a_dv_seen", dv_of(s), 1);
        at = cyc;
    endtask

    task automatic wait_idle(input int s, input int bound, output int n);
        n = 0;
        while (busy_of(s) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check((s != 0) ? "b_idle_reached" : "a_idle_reached", busy_of(s), 0);
    endtask

    task automatic wait_cs_fall(input int s, input int bound);
        int n = 0;
        while (cs_of(s) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check((s != 0) ? "b_cs_fall_seen" : "a_cs_fall_seen", cs_of(s), 0);
    endtask

    typedef struct {
        logic [7:0] adc;
        logic [7:0] exp_data;
        int         exp_gap;
    } vec_t;

    vec_t       tbl_a[4];
    vec_t       tbl_b[2];
    logic [7:0] rnd[20];

    initial begin
        int t, prev, n, lows;
        tbl_a[0] = '{8'h00, 8'h00, 0};
        tbl_a[1] = '{8'hFF, 8'hFF, 1476};
        tbl_a[2] = '{8'h80, 8'h80, 1476};
        tbl_a[3] = '{8'h01, 8'h01, 1476};
        tbl_b[0] = '{8'hC3, 8'hC3, 0};
        tbl_b[1] = '{8'h7E, 8'h7E, 55};

        // Reset held with enable high and adc_dout toggling
        en_a = 1'b1;
        en_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            noise = ~noise;
            @(negedge clk);
            check("a_reset_outputs", {cs_a, sclk_a, data_a, dv_a, busy_a}, 12'h800);
            check("b_reset_outputs", {cs_b, sclk_b, data_b, dv_b, busy_b}, 12'h800);
        end
        noise = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame from a one-cycle enable pulse
        q_a.push_back(8'hA5);
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        wait_dv(0, 3000, t);
        check("a_single_data", data_a, 8'hA5);
        wait_idle(0, 3000, n);
        check("a_busy_drop_after_dv", n, 1001);

        // Continuous conversion with enable held high
        for (int i = 0; i < 4; i++) q_a.push_back(tbl_a[i].adc);
        @(negedge clk);
        en_a = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_dv(0, 5000, t);
            check("a_cont_data", data_a, tbl_a[i].exp_data);
            if (i > 0) check("a_cont_gap", t - prev, tbl_a[i].exp_gap);
            prev = t;
        end
        en_a = 1'b0;
        wait_idle(0, 3000, n);

        // Enable dropped during the third bit: frame and WAIT still complete
        q_a.push_back(8'h3C);
        @(negedge clk);
        en_a = 1'b1;
        wait_cs_fall(0, 100);
        repeat (185) @(negedge clk);
        check("a_drop_in_shift", busy_a, 1);
        en_a = 1'b0;
        wait_dv(0, 3000, t);
        check("a_drop_data", data_a, 8'h3C);
        wait_idle(0, 3000, n);
        check("a_drop_wait_len", n, 1001);
        lows = 0;
        repeat (1600) begin
            @(negedge clk);
            if (!cs_a) lows++;
        end
        check("a_no_frame_after_drop", lows, 0);

        // Reset in the middle of the fifth bit, after four captures
        q_a.push_back(8'h99);
        en_a = 1'b1;
        wait_cs_fall(0, 100);
        repeat (285) @(negedge clk);
        check("a_mid_sclk_high", sclk_a, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("a_mid_reset_now", {cs_a, sclk_a, data_a, dv_a, busy_a}, 12'h800);
        q_a.push_back(8'h5A);
        repeat (3) begin
            @(negedge clk);
            check("a_mid_reset_hold", {cs_a, sclk_a, data_a, dv_a, busy_a}, 12'h800);
        end
        rst_n = 1'b1;
        wait_dv(0, 3000, t);
        check("a_after_reset_data", data_a, 8'h5A);
        en_a = 1'b0;
        wait_idle(0, 3000, n);

        // Minimum parameters: table entries then randomized data, enable held high
        for (int i = 0; i < 2; i++) q_b.push_back(tbl_b[i].adc);
        for (int i = 0; i < 20; i++) begin
            rnd[i] = 8'($urandom);
            q_b.push_back(rnd[i]);
        end
        @(negedge clk);
        en_b = 1'b1;
        prev = 0;
        for (int i = 0; i < 2; i++) begin
            wait_dv(1, 500, t);
            check("b_tbl_data", data_b, tbl_b[i].exp_data);
            if (i > 0) check("b_tbl_gap", t - prev, tbl_b[i].exp_gap);
            prev = t;
        end
        for (int i = 0; i < 20; i++) begin
            wait_dv(1, 500, t);
            check("b_rnd_data", data_b, rnd[i]);
            check("b_rnd_gap", t - prev, 55);
            prev = t;
        end
        en_b = 1'b0;
        wait_idle(1, 500, n);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
- Master-side controller for an 8-bit serial ADC (chip-select, serial clock, serial data out).
- Runs repeated conversion frames and shifts in 8 bits, MSB first.
- Presents each result as audio_data with a one-cycle data_valid strobe, which is the producer side of the audio_data/data_valid interface consumed by the level-indicator and spectrum blocks.
- Sits between the board ADC pins and all audio-processing logic.

Parameters:
- CLK_DIV, 25: clk cycles per adc_sclk half-period (50 MHz clk gives 1 MHz sclk). Legal minimum is 3.
- CS_SETUP, 75: clk cycles between adc_cs_n falling and the first adc_sclk rising edge. Legal minimum is 1.
- CONV_CYCLES, 1000: clk cycles adc_cs_n is held high after a frame, covering the ADC conversion time. Legal minimum is 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- enable  input  1  continuous-conversion request, level sensitive
- adc_dout  input  1  ADC serial data; asynchronous to clk
- adc_cs_n  output  1  ADC chip select, active low
- adc_sclk  output  1  ADC serial clock, idles low
- audio_data  output  8  last completed sample
- data_valid  output  1  one-cycle strobe; audio_data is new in this cycle
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset rst_n is asynchronous and active-low; clock is clk. All outputs are registered.
- Reset values: adc_cs_n=1, adc_sclk=0, audio_data=8'h00, data_valid=0, busy=0, FSM=IDLE, all counters and the shift register cleared.
- adc_dout passes through a 2-flop synchronizer. The bit sampler uses only the synchronized value.
- FSM states: IDLE, SETUP, SHIFT, DONE, WAIT.
  - IDLE: cs_n=1, sclk=0. When enable=1, go to SETUP next edge and drive cs_n=0 on that same edge.
  - SETUP: cs_n=0, sclk=0 for exactly CS_SETUP cycles, then go to SHIFT.
  - SHIFT: 8 bit periods, each sclk=1 for CLK_DIV cycles then sclk=0 for CLK_DIV cycles. SHIFT lasts exactly 16*CLK_DIV cycles.
  - SHIFT capture: the synchronized adc_dout is shifted in (MSB first) on the last cycle of each high phase. After the 8th low phase, go to DONE.
  - DONE: exactly 1 cycle. cs_n=1, sclk=0, audio_data loaded with the 8 captured bits, data_valid=1. Go to WAIT.
  - WAIT: cs_n=1, sclk=0 for exactly CONV_CYCLES cycles. Then go to SETUP if enable=1, else IDLE.
- Per-frame timing:
  - cs_n low window = CS_SETUP + 16*CLK_DIV cycles.
  - Sample period with enable held high = CS_SETUP + 16*CLK_DIV + 1 + CONV_CYCLES (1476 cycles at defaults, about 33.9 kHz).
  - Exactly 8 sclk rising edges per frame, all within the cs_n low window.
- audio_data holds its value between DONE cycles. data_valid is never high for two consecutive cycles.
- enable is sampled only in IDLE and at the end of WAIT. Deasserting enable mid-frame never truncates the frame: SHIFT, DONE and WAIT all complete, then the FSM returns to IDLE.
- Reset mid-frame: outputs return immediately to reset values. The partial frame is discarded with no data_valid, and the next frame after release starts from IDLE.
- busy=1 in SETUP, SHIFT, DONE and WAIT.
- Expected ADC behaviour: MSB is valid on adc_dout after cs_n falls; the ADC updates adc_dout on sclk falling edges. CLK_DIV>=3 guarantees synchronizer settling before capture.

Test Plan:
- Reset: rst_n=0 with enable=1 and adc_dout toggling -> adc_cs_n=1, adc_sclk=0, audio_data=8'h00, data_valid=0, busy=0 throughout.
- Single frame, defaults: ADC model returns 8'hA5; pulse enable high for 1 cycle.
  - data_valid high exactly 1 cycle with audio_data=8'hA5.
  - cs_n low for exactly 475 cycles; exactly 8 sclk rising edges.
  - busy drops 1001 cycles after data_valid.
- Continuous, defaults: enable held high, model returns 8'h00, 8'hFF, 8'h80, 8'h01 -> four data_valid strobes spaced exactly 1476 cycles apart, with values in that order.
- Enable drop: enable deasserted during the 3rd bit of SHIFT, model returns 8'h3C -> frame completes with audio_data=8'h3C; WAIT completes, then IDLE with busy=0 and no further cs_n fall.
- Mid-frame reset: rst_n pulsed low after 4 captured bits -> cs_n=1 and sclk=0 in the same cycle, no data_valid. After release with enable=1 and model returning 8'h5A, the first strobe carries 8'h5A.
- Minimum parameters: CLK_DIV=3, CS_SETUP=2, CONV_CYCLES=4 with continuous enable and values 8'hC3, 8'h7E -> strobes 55 cycles apart carrying the correct values.
